// File: rtl/lms_error_engine_if.sv
// LMS error engine bus: sample input, result strobe and
// per-tap weight-update request/write-back channel.
interface lms_error_engine_if #(
  parameter int TAPS = 8,
  parameter int DW   = 16
);
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] d_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] e_out;
  logic                 out_valid;
  logic                 upd_valid;
  logic                 upd_ready;
  logic [KW-1:0]        upd_idx;
  logic signed [DW-1:0] upd_x;
  logic signed [DW-1:0] upd_e;
  logic signed [DW-1:0] upd_w;
  logic                 wb_valid;
  logic signed [DW-1:0] wb_data;

  modport master (
    input  x_in, d_in, in_valid,
    input  upd_ready, wb_valid, wb_data,
    output in_ready, y_out, e_out, out_valid,
    output upd_valid, upd_idx, upd_x, upd_e, upd_w
  );

  modport slave (
    output x_in, d_in, in_valid,
    output upd_ready, wb_valid, wb_data,
    input  in_ready, y_out, e_out, out_valid,
    input  upd_valid, upd_idx, upd_x, upd_e, upd_w
  );
endinterface

// File: rtl/lms_error_engine.sv
// Serial LMS filter/error engine: one MAC per cycle, then a
// per-tap weight-update handshake with the adaptation side.
module lms_error_engine #(
  parameter int TAPS = 8,
  parameter int DW   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  lms_error_engine_if.master bus
);
  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = 2 * DW;
  localparam int AW = PW + KW;
  localparam logic [KW-1:0] KMAX = KW'(TAPS - 1);
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, SHIFT, MAC, ERR, UPD_REQ, UPD_WAIT
  } state_t;

  state_t state;

  logic signed [DW-1:0] x [TAPS];
  logic signed [DW-1:0] w [TAPS];
  logic signed [DW-1:0] x_new;
  logic signed [DW-1:0] d_q;
  logic signed [AW-1:0] acc;
  logic [KW-1:0]        k;
  logic [KW-1:0]        kn;
  logic                 ov_q;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sh;
  logic                 y_fit;
  logic signed [DW-1:0] y_sat;
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] e_sat;

  assign kn    = k + KW'(1);
  assign prod  = PW'(w[k]) * PW'(x[k]);
  assign sh    = acc >>> (DW - 1);
  assign y_fit = (&sh[AW-1:DW-1]) | ~(|sh[AW-1:DW-1]);
  assign y_sat = y_fit ? sh[DW-1:0] : (sh[AW-1] ? SMIN : SMAX);
  assign diff  = {d_q[DW-1], d_q} - {y_sat[DW-1], y_sat};
  assign e_sat = (diff[DW] == diff[DW-1]) ? diff[DW-1:0]
               : (diff[DW] ? SMIN : SMAX);

  assign bus.in_ready  = en && (state == IDLE);
  assign bus.out_valid = ov_q && en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      x_new         <= '0;
      d_q           <= '0;
      acc           <= '0;
      k             <= '0;
      ov_q          <= 1'b0;
      bus.y_out     <= '0;
      bus.e_out     <= '0;
      bus.upd_valid <= 1'b0;
      bus.upd_idx   <= '0;
      bus.upd_x     <= '0;
      bus.upd_e     <= '0;
      bus.upd_w     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        w[i] <= '0;
      end
    end else begin
      // the result strobe never survives past one clock
      ov_q <= 1'b0;
      if (en) begin
        unique case (state)
          IDLE: begin
            if (bus.in_valid) begin
              x_new <= bus.x_in;
              d_q   <= bus.d_in;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            x[0] <= x_new;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
          MAC: begin
            acc <= acc + AW'(prod);
            if (k == KMAX) state <= ERR;
            else           k     <= kn;
          end
          ERR: begin
            bus.y_out     <= y_sat;
            bus.e_out     <= e_sat;
            ov_q          <= 1'b1;
            k             <= '0;
            bus.upd_valid <= 1'b1;
            bus.upd_idx   <= '0;
            bus.upd_x     <= x[0];
            bus.upd_e     <= e_sat;
            bus.upd_w     <= w[0];
            state         <= UPD_REQ;
          end
          UPD_REQ: begin
            if (bus.upd_ready) begin
              bus.upd_valid <= 1'b0;
              state         <= UPD_WAIT;
            end
          end
          UPD_WAIT: begin
            if (bus.wb_valid) begin
              w[k] <= bus.wb_data;
              if (k == KMAX) begin
                state <= IDLE;
              end else begin
                k             <= kn;
                bus.upd_valid <= 1'b1;
                bus.upd_idx   <= kn;
                bus.upd_x     <= x[kn];
                bus.upd_w     <= w[kn];
                state         <= UPD_REQ;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lms_error_engine.sv
// Randomized bench for lms_error_engine against a
// plain-arithmetic LMS filter/error model.
module tb_lms_error_engine;
  localparam int TAPS = 8;
  localparam int DW   = 16;

  logic clk;
  logic reset;
  logic en;

  lms_error_engine_if #(.TAPS(TAPS), .DW(DW)) bus ();

  lms_error_engine #(.TAPS(TAPS), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int fails;

  int xm [TAPS];
  int wm [TAPS];
  int exp_y;
  int exp_e;
  logic [DW-1:0] wb_q [TAPS];

  function automatic int sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      xm[i] = 0;
      wm[i] = 0;
    end
  endtask

  task automatic do_sample(input logic [DW-1:0] xv,
                           input logic [DW-1:0] dv,
                           input int pause_at);
    longint acc;
    int n;
    int want;
    logic [DW-1:0] ey;
    logic [DW-1:0] ee;
    for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = sx(xv);
    acc = 0;
    for (int i = 0; i < TAPS; i++)
      acc += longint'(xm[i]) * longint'(wm[i]);
    exp_y = sat(acc >>> 15);
    exp_e = sat(longint'(sx(dv)) - longint'(exp_y));
    ey = exp_y[DW-1:0];
    ee = exp_e[DW-1:0];
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.x_in = xv;
    bus.d_in = dv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x_in = $urandom;
    bus.d_in = $urandom;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (n == pause_at) begin
        en = 1'b0;
        bus.in_valid = 1'b1;
      end
      if (n == pause_at + 5) begin
        en = 1'b1;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    want = (pause_at >= 0) ? TAPS + 7 : TAPS + 2;
    checks++;
    if (n !== want) begin
      fails++;
      $display("FAIL latency got=%0d want=%0d", n, want);
    end
    checks++;
    if (bus.y_out !== ey) begin
      fails++;
      $display("FAIL y_out got=%h want=%h", bus.y_out, ey);
    end
    checks++;
    if (bus.e_out !== ee) begin
      fails++;
      $display("FAIL e_out got=%h want=%h", bus.e_out, ee);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL out_valid_width got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic serve_pass(input int stall_idx, input int abort_idx);
    int n;
    logic [DW-1:0] ex;
    logic [DW-1:0] ew;
    logic [DW-1:0] ee;
    logic [DW-1:0] sx0, se0, sw0;
    logic [2:0]    si0;
    ee = exp_e[DW-1:0];
    for (int i = 0; i < TAPS; i++) begin
      n = 0;
      while (bus.upd_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 100) begin
        fails++;
        $display("FAIL upd_timeout idx=%0d", i);
        return;
      end
      ex = xm[i][DW-1:0];
      ew = wm[i][DW-1:0];
      checks++;
      if (bus.upd_idx !== 3'(i) || bus.upd_x !== ex ||
          bus.upd_w !== ew || bus.upd_e !== ee) begin
        fails++;
        $display("FAIL upd_req got=%0d/%h/%h/%h want=%0d/%h/%h/%h",
                 bus.upd_idx, bus.upd_x, bus.upd_w, bus.upd_e,
                 i, ex, ew, ee);
      end
      if (i == stall_idx) begin
        si0 = bus.upd_idx;
        sx0 = bus.upd_x;
        se0 = bus.upd_e;
        sw0 = bus.upd_w;
        for (int c = 0; c < 20; c++) begin
          bus.wb_valid = (c % 4 == 1);
          bus.wb_data  = 16'h1234;
          bus.in_valid = 1'b1;
          @(negedge clk);
          checks++;
          if (bus.upd_valid !== 1'b1 || bus.upd_idx !== si0 ||
              bus.upd_x !== sx0 || bus.upd_e !== se0 ||
              bus.upd_w !== sw0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall c=%0d v=%b idx=%0d rdy=%b want v=1 idx=%0d rdy=0",
                     c, bus.upd_valid, bus.upd_idx, bus.in_ready, si0);
          end
        end
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
      end
      bus.upd_ready = 1'b1;
      @(negedge clk);
      bus.upd_ready = 1'b0;
      checks++;
      if (bus.upd_valid !== 1'b0) begin
        fails++;
        $display("FAIL upd_drop got=%b want=0", bus.upd_valid);
      end
      if (i == abort_idx) return;
      bus.wb_valid = 1'b1;
      bus.wb_data  = wb_q[i];
      @(negedge clk);
      bus.wb_valid = 1'b0;
      wm[i] = sx(wb_q[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.y_out !== '0 || bus.e_out !== '0 ||
        bus.out_valid !== 1'b0 || bus.upd_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs y=%h e=%h ov=%b uv=%b want 0",
               bus.y_out, bus.e_out, bus.out_valid, bus.upd_valid);
    end
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_first_sample();
    do_sample(16'h4000, 16'h2000, -1);
    checks++;
    if (bus.y_out !== 16'h0000 || bus.e_out !== 16'h2000) begin
      fails++;
      $display("FAIL first_const y=%h e=%h want 0000/2000",
               bus.y_out, bus.e_out);
    end
    for (int i = 0; i < TAPS; i++) wb_q[i] = (i == 0) ? 16'h4000 : 16'h0;
    serve_pass(-1, -1);
  endtask

  task automatic test_second_sample();
    do_sample(16'h4000, 16'h0000, -1);
    checks++;
    if (bus.y_out !== 16'h2000 || bus.e_out !== 16'hE000) begin
      fails++;
      $display("FAIL second_const y=%h e=%h want 2000/E000",
               bus.y_out, bus.e_out);
    end
    for (int i = 0; i < TAPS; i++) wb_q[i] = 16'h7FFF;
    serve_pass(-1, -1);
  endtask

  task automatic test_saturate();
    for (int s = 0; s < TAPS; s++) begin
      do_sample(16'h7FFF, (s == TAPS - 1) ? 16'h8000 : 16'h0000, -1);
      serve_pass(-1, -1);
    end
    checks++;
    if (bus.y_out !== 16'h7FFF || bus.e_out !== 16'h8000) begin
      fails++;
      $display("FAIL saturate y=%h e=%h want 7FFF/8000",
               bus.y_out, bus.e_out);
    end
  endtask

  task automatic test_stall();
    do_sample(DW'($urandom), DW'($urandom), -1);
    for (int i = 0; i < TAPS; i++) wb_q[i] = DW'($urandom_range(0, 16'h3FFF));
    serve_pass(3, -1);
    do_sample(DW'($urandom), DW'($urandom), -1);
    for (int i = 0; i < TAPS; i++) wb_q[i] = DW'($urandom);
    serve_pass(-1, -1);
  endtask

  task automatic test_pause();
    do_sample(DW'($urandom), DW'($urandom), 3);
    for (int i = 0; i < TAPS; i++) wb_q[i] = DW'($urandom);
    serve_pass(-1, -1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      do_sample(DW'($urandom), DW'($urandom), -1);
      for (int i = 0; i < TAPS; i++) wb_q[i] = DW'($urandom);
      serve_pass(-1, -1);
    end
  endtask

  task automatic test_reset_mid();
    do_sample(DW'($urandom), DW'($urandom), -1);
    for (int i = 0; i < TAPS; i++) wb_q[i] = DW'($urandom);
    serve_pass(-1, 2);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.y_out !== '0 || bus.e_out !== '0 || bus.upd_valid !== 1'b0 ||
        bus.upd_idx !== '0 || bus.upd_x !== '0 || bus.upd_e !== '0 ||
        bus.upd_w !== '0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset y=%h e=%h uv=%b idx=%0d ux=%h ue=%h uw=%h want 0",
               bus.y_out, bus.e_out, bus.upd_valid, bus.upd_idx,
               bus.upd_x, bus.upd_e, bus.upd_w);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    do_sample(DW'($urandom), DW'($urandom), -1);
    checks++;
    if (bus.y_out !== 16'h0000) begin
      fails++;
      $display("FAIL post_reset_y got=%h want=0000", bus.y_out);
    end
    for (int i = 0; i < TAPS; i++) wb_q[i] = '0;
    serve_pass(-1, -1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    en     = 1'b1;
    bus.x_in      = '0;
    bus.d_in      = '0;
    bus.in_valid  = 1'b0;
    bus.upd_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_data   = '0;
    test_reset();
    test_first_sample();
    test_second_sample();
    test_saturate();
    test_stall();
    test_pause();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/lms_error_engine.md
LMS_ERROR_ENGINE -- requirements
Module: lms_error_engine

Interface
REQ-001 SHALL have parameter TAPS, default 8, meaning filter length (power of 2, 2..32).
REQ-002 SHALL have parameter DW, default 16, meaning sample/weight/error width, signed Q1.15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  global enable; low freezes all state.
REQ-006 SHALL have port x_in  input  DW  new input sample.
REQ-007 SHALL have port d_in  input  DW  desired sample paired with x_in.
REQ-008 SHALL have port in_valid  input  1  x_in/d_in valid.
REQ-009 SHALL have port in_ready  output  1  engine can accept a sample.
REQ-010 SHALL have port y_out  output  DW  filter output.
REQ-011 SHALL have port e_out  output  DW  error d - y.
REQ-012 SHALL have port out_valid  output  1  one-cycle strobe, y_out/e_out valid.
REQ-013 SHALL have port upd_valid  output  1  weight-update request to adaptation side.
REQ-014 SHALL have port upd_ready  input  1  adaptation side accepts request.
REQ-015 SHALL have port upd_idx  output  log2(TAPS)  tap index of request.
REQ-016 SHALL have ports upd_x, upd_e, upd_w  output  DW each  tap sample, current error, current weight.
REQ-017 SHALL have port wb_valid  input  1  updated weight returned.
REQ-018 SHALL have port wb_data  input  DW  updated weight value for upd_idx.

Function
REQ-019 SHALL hold internal delay line x[0..TAPS-1] and weight file w[0..TAPS-1], DW signed each.
REQ-020 SHALL implement FSM IDLE -> SHIFT -> MAC -> ERR -> UPD_REQ -> UPD_WAIT -> (UPD_REQ for next tap | IDLE after tap TAPS-1).
REQ-021 in_ready SHALL be 1 only in IDLE with en=1; sample accepted on edge with in_valid & in_ready.
REQ-022 SHIFT (1 cycle): x[k] <= x[k-1] for k>=1, x[0] <= accepted x_in; d_in captured at acceptance.
REQ-023 MAC: exactly TAPS cycles, one product w[k]*x[k] per cycle, k=0..TAPS-1, accumulated in DW*2+log2(TAPS) bit signed accumulator cleared on entry.
REQ-024 y = acc arithmetic-shifted right by DW-1, saturated to [0x8000, 0x7FFF] (DW=16).
REQ-025 ERR (1 cycle): e = d - y computed in DW+1 bits, saturated to DW; y_out, e_out registered; out_valid high exactly one cycle, TAPS+2 enabled cycles after accepting edge.
REQ-026 y_out/e_out SHALL hold value until next ERR.
REQ-027 UPD_REQ: upd_valid=1, upd_idx=k, upd_x=x[k], upd_e=e, upd_w=w[k]; all fields stable until upd_valid & upd_ready edge, then go to UPD_WAIT with upd_valid=0.
REQ-028 UPD_WAIT: on wb_valid, w[k] <= wb_data; k increments; after k=TAPS-1 return to IDLE.
REQ-029 wb_valid outside UPD_WAIT SHALL be ignored; no timeout on upd_ready or wb_valid (stall indefinitely).
REQ-030 in_valid while not IDLE SHALL be ignored (no sample queued).
REQ-031 en=0 SHALL hold FSM, counters, registers, outputs; out_valid forced 0, upd_valid holds, handshakes not accepted.
REQ-032 Weights updated within one update pass SHALL not affect y/e already produced; next sample uses all new weights.

Reset
REQ-033 reset low SHALL immediately clear x[], w[], accumulator, tap counter, y_out, e_out, upd_* outputs to 0, out_valid=0, FSM=IDLE; in_ready=1 after release (en=1).
REQ-034 Reset mid-operation SHALL discard the in-flight sample and any partial update pass.

Verification
REQ-035 After reset, x_in=0x4000, d_in=0x2000 -> out_valid at cycle TAPS+2, y_out=0x0000, e_out=0x2000; 8 requests idx 0..7, upd_x=0x4000 at idx0 else 0, upd_w=0, upd_e=0x2000.
REQ-036 Return wb_data=0x4000 for idx0, 0 others; next sample x_in=0x4000, d_in=0 -> y_out=0x2000, e_out=0xE000.
REQ-037 Weights all written 0x7FFF, delay line filled 0x7FFF, d_in=0x8000 -> y_out=0x7FFF (saturated), e_out=0x8000 (saturated).
REQ-038 upd_ready held low 20 cycles at idx 3 -> upd_valid stays 1, idx/x/e/w stable, in_ready=0, wb_valid pulses ignored.
REQ-039 en low 5 cycles during MAC -> out_valid delayed by exactly 5 cycles, y_out unchanged vs. un-paused run.
REQ-040 reset asserted in UPD_WAIT idx 2 -> all outputs 0 same cycle; next sample yields y_out=0.
